// File: rtl/asic_padcfg_pkg.sv
// Shared types and constants for the pad configuration controller:
// sequencer states, register word addresses and pad safe values.
package asic_padcfg_pkg;

   typedef enum logic [1:0] {
      ST_SAFE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_APPLY = 2'd2,
      ST_RUN   = 2'd3
   } padcfg_state_e;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_DELAY  = 8'h02;
   localparam logic [7:0] SIDE_STRIDE = 8'h10;

   localparam logic [3:0] OFF_IE   = 4'h0;
   localparam logic [3:0] OFF_OEN  = 4'h1;
   localparam logic [3:0] OFF_TECH = 4'h2;
   localparam logic [3:0] OFF_CFG0 = 4'h4;

   localparam logic       SAFE_IE   = 1'b0;
   localparam logic       SAFE_OEN  = 1'b1;
   localparam logic [7:0] DELAY_RST = 8'h10;

endpackage

// File: rtl/asic_padcfg_side.sv
// One padring side: shadow registers, live bit, safe/live output muxing
// and replication of the side-wide TECH word to every pad.
module asic_padcfg_side
   import asic_padcfg_pkg::*;
#(
   parameter int NGPIO = 9,
   parameter int CFGW  = 8,
   parameter int TECHW = 16,
   parameter int WW    = 16,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   srst,
   input  logic                   wr_en,
   input  logic [3:0]             wr_off,
   input  logic [WW-1:0]          wr_data,
   input  logic                   go_live,
   input  logic [3:0]             rd_off,
   output logic [DW-1:0]          rd_data,
   output logic [NGPIO-1:0]       ie,
   output logic [NGPIO-1:0]       oen,
   output logic [NGPIO*CFGW-1:0]  cfg,
   output logic [NGPIO*TECHW-1:0] tech
);

   logic [NGPIO-1:0] ie_mask_r;
   logic [NGPIO-1:0] oen_mask_r;
   logic [TECHW-1:0] tech_r;
   logic [TECHW-1:0] tech_out_r;
   logic [CFGW-1:0]  cfg_r [NGPIO];
   logic             live_r;
   logic             live_next_s;

   // Shadow registers: only hard reset clears them, force_safe keeps them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie_mask_r  <= {NGPIO{SAFE_IE}};
         oen_mask_r <= {NGPIO{SAFE_OEN}};
         tech_r     <= {TECHW{1'b0}};
         for (int p = 0; p < NGPIO; p++) cfg_r[p] <= {CFGW{1'b0}};
      end else if (wr_en) begin
         case (wr_off)
            OFF_IE:   ie_mask_r  <= wr_data[NGPIO-1:0];
            OFF_OEN:  oen_mask_r <= wr_data[NGPIO-1:0];
            OFF_TECH: tech_r     <= wr_data[TECHW-1:0];
            default: begin
               for (int p = 0; p < NGPIO; p++) begin
                  if (wr_off == OFF_CFG0 + 4'(p)) cfg_r[p] <= wr_data[CFGW-1:0];
               end
            end
         endcase
      end
   end

   // Live bit: set by the sequencer's APPLY, cleared by force_safe
   always_comb begin
      if (srst) begin
         live_next_s = 1'b0;
      end else begin
         live_next_s = live_r | go_live;
      end
   end

   // Live bit register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live_r <= 1'b0;
      else        live_r <= live_next_s;
   end

   // Registered pad outputs follow the next live value so APPLY shows on the following edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie         <= {NGPIO{SAFE_IE}};
         oen        <= {NGPIO{SAFE_OEN}};
         tech_out_r <= {TECHW{1'b0}};
         cfg        <= {(NGPIO*CFGW){1'b0}};
      end else if (live_next_s) begin
         ie         <= ie_mask_r;
         oen        <= oen_mask_r;
         tech_out_r <= tech_r;
         for (int p = 0; p < NGPIO; p++) cfg[p*CFGW +: CFGW] <= cfg_r[p];
      end else begin
         ie         <= {NGPIO{SAFE_IE}};
         oen        <= {NGPIO{SAFE_OEN}};
         tech_out_r <= {TECHW{1'b0}};
         cfg        <= {(NGPIO*CFGW){1'b0}};
      end
   end

   assign tech = {NGPIO{tech_out_r}};

   // Shadow readback; offset 3 and offsets past the last pad read as zero
   always_comb begin
      rd_data = {DW{1'b0}};
      case (rd_off)
         OFF_IE:   rd_data[NGPIO-1:0] = ie_mask_r;
         OFF_OEN:  rd_data[NGPIO-1:0] = oen_mask_r;
         OFF_TECH: rd_data[TECHW-1:0] = tech_r;
         default: begin
            for (int p = 0; p < NGPIO; p++) begin
               rd_data[CFGW-1:0] = rd_data[CFGW-1:0] |
                  ((rd_off == OFF_CFG0 + 4'(p)) ? cfg_r[p] : {CFGW{1'b0}});
            end
         end
      endcase
   end

endmodule

// File: rtl/asic_padcfg_ctrl.sv
// Pad configuration controller top: register bus decode, power-up
// sequencer (safe -> per-side staged enable) and registered read path.
module asic_padcfg_ctrl
   import asic_padcfg_pkg::*;
#(
   parameter int NSIDES = 4,
   parameter int NGPIO  = 9,
   parameter int CFGW   = 8,
   parameter int TECHW  = 16,
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int DELAYW = 8
) (
   input  logic                          clk,
   input  logic                          nreset,
   input  logic                          reg_valid,
   input  logic                          reg_write,
   input  logic [AW-1:0]                 reg_addr,
   input  logic [DW-1:0]                 reg_wdata,
   output logic                          reg_ready,
   output logic                          reg_rvalid,
   output logic [DW-1:0]                 reg_rdata,
   output logic [NSIDES*NGPIO*CFGW-1:0]  pad_cfg,
   output logic [NSIDES*NGPIO-1:0]       pad_ie,
   output logic [NSIDES*NGPIO-1:0]       pad_oen,
   output logic [NSIDES*NGPIO*TECHW-1:0] pad_tech_cfg,
   output logic                          seq_done
);

   localparam int WW = (TECHW >= CFGW) ? ((TECHW >= NGPIO) ? TECHW : NGPIO)
                                       : ((CFGW >= NGPIO) ? CFGW : NGPIO);

   padcfg_state_e     state_r, state_next_s;
   logic [7:0]        idx_r, idx_next_s;
   logic [DELAYW-1:0] delay_r, cnt_r, cnt_next_s;
   logic              seq_done_r, done_next_s, apply_s;
   logic              wr_s, rd_s, start_s, force_s;
   logic [DW-1:0]     side_rd_s [NSIDES];
   logic [DW-1:0]     rdata_next_s;
   logic              unused_s;

   assign reg_ready = 1'b1;
   assign wr_s      = reg_valid & reg_write;
   assign rd_s      = reg_valid & ~reg_write;
   assign start_s   = wr_s & (reg_addr == AW'(ADDR_CTRL)) & reg_wdata[0];
   assign force_s   = wr_s & (reg_addr == AW'(ADDR_CTRL)) & reg_wdata[1];
   assign unused_s  = ^reg_wdata[DW-1:WW];
   assign seq_done  = seq_done_r;

   // Inter-side delay register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                                    delay_r <= DELAYW'(DELAY_RST);
      else if (wr_s && reg_addr == AW'(ADDR_DELAY))   delay_r <= reg_wdata[DELAYW-1:0];
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r    <= ST_SAFE;
         idx_r      <= 8'd0;
         cnt_r      <= {DELAYW{1'b0}};
         seq_done_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         idx_r      <= idx_next_s;
         cnt_r      <= cnt_next_s;
         seq_done_r <= done_next_s;
      end
   end

   // Sequencer next state; force_safe overrides everything including start
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      cnt_next_s   = cnt_r;
      done_next_s  = seq_done_r;
      apply_s      = 1'b0;
      if (force_s) begin
         state_next_s = ST_SAFE;
         idx_next_s   = 8'd0;
         cnt_next_s   = {DELAYW{1'b0}};
         done_next_s  = 1'b0;
      end else begin
         case (state_r)
            ST_SAFE: begin
               if (start_s) begin
                  state_next_s = ST_WAIT;
                  idx_next_s   = 8'd0;
                  cnt_next_s   = delay_r;
               end else begin
                  state_next_s = ST_SAFE;
               end
            end
            ST_WAIT: begin
               if (cnt_r == {DELAYW{1'b0}}) state_next_s = ST_APPLY;
               else                         cnt_next_s   = cnt_r - DELAYW'(1);
            end
            ST_APPLY: begin
               apply_s = 1'b1;
               if (idx_r < 8'(NSIDES - 1)) begin
                  state_next_s = ST_WAIT;
                  idx_next_s   = idx_r + 8'd1;
                  cnt_next_s   = delay_r;
               end else begin
                  state_next_s = ST_RUN;
                  done_next_s  = 1'b1;
               end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_SAFE;
         endcase
      end
   end

   for (genvar s = 0; s < NSIDES; s++) begin : g_side
      localparam logic [AW-1:0] BASE = AW'(SIDE_STRIDE) * AW'(s + 1);
      logic          hit_s;
      logic [DW-1:0] raw_rd_s;

      assign hit_s        = (reg_addr[AW-1:4] == BASE[AW-1:4]);
      assign side_rd_s[s] = hit_s ? raw_rd_s : {DW{1'b0}};

      asic_padcfg_side #(
         .NGPIO(NGPIO), .CFGW(CFGW), .TECHW(TECHW), .WW(WW), .DW(DW)
      ) u_side (
         .clk     (clk),
         .rst_n   (nreset),
         .srst    (force_s),
         .wr_en   (wr_s & hit_s),
         .wr_off  (reg_addr[3:0]),
         .wr_data (reg_wdata[WW-1:0]),
         .go_live (apply_s && (idx_r == 8'(s))),
         .rd_off  (reg_addr[3:0]),
         .rd_data (raw_rd_s),
         .ie      (pad_ie[s*NGPIO +: NGPIO]),
         .oen     (pad_oen[s*NGPIO +: NGPIO]),
         .cfg     (pad_cfg[s*NGPIO*CFGW +: NGPIO*CFGW]),
         .tech    (pad_tech_cfg[s*NGPIO*TECHW +: NGPIO*TECHW])
      );
   end

   // Read data select; CTRL is write-only pulses and reads as zero
   always_comb begin
      rdata_next_s = {DW{1'b0}};
      case (reg_addr)
         AW'(ADDR_STATUS): rdata_next_s[15:0]       = {idx_r, 6'b000000, state_r};
         AW'(ADDR_DELAY):  rdata_next_s[DELAYW-1:0] = delay_r;
         default: begin
            for (int s = 0; s < NSIDES; s++) rdata_next_s = rdata_next_s | side_rd_s[s];
         end
      endcase
   end

   // Registered read response; rdata holds between reads
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         reg_rvalid <= 1'b0;
         reg_rdata  <= {DW{1'b0}};
      end else begin
         reg_rvalid <= rd_s;
         if (rd_s) reg_rdata <= rdata_next_s;
      end
   end

endmodule

// File: tb/tb_asic_padcfg_ctrl.sv
// Self-checking bench for asic_padcfg_ctrl: read scoreboard plus a
// per-cycle model of the staged padring bring-up.
module tb_asic_padcfg_ctrl;

   localparam int NS = 4, NG = 9, CW = 8, TW = 16;

   logic         clk = 1'b0;
   logic         nreset;
   logic         reg_valid, reg_write;
   logic [7:0]   reg_addr;
   logic [31:0]  reg_wdata;
   logic         reg_ready, reg_rvalid;
   logic [31:0]  reg_rdata;
   logic [287:0] pad_cfg;
   logic [35:0]  pad_ie, pad_oen;
   logic [575:0] pad_tech_cfg;
   logic         seq_done;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];

   logic [8:0]  m_ie   [NS];
   logic [8:0]  m_oen  [NS];
   logic [15:0] m_tech [NS];
   logic [7:0]  m_cfg  [NS][NG];
   int          m_delay;

   asic_padcfg_ctrl dut (
      .clk(clk), .nreset(nreset), .reg_valid(reg_valid), .reg_write(reg_write),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ready(reg_ready),
      .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata), .pad_cfg(pad_cfg),
      .pad_ie(pad_ie), .pad_oen(pad_oen), .pad_tech_cfg(pad_tech_cfg),
      .seq_done(seq_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         m_ie[s] = 9'h000; m_oen[s] = 9'h1FF; m_tech[s] = 16'h0000;
         for (int p = 0; p < NG; p++) m_cfg[s][p] = 8'h00;
      end
      m_delay = 16;
   endtask

   task automatic check_pads(input string tag, input logic [3:0] live, input logic done);
      logic [35:0]  e_ie, e_oen;
      logic [287:0] e_cfg;
      logic [575:0] e_tech;
      for (int s = 0; s < NS; s++) begin
         for (int p = 0; p < NG; p++) begin
            e_ie[s*NG+p]            = live[s] ? m_ie[s][p]  : 1'b0;
            e_oen[s*NG+p]           = live[s] ? m_oen[s][p] : 1'b1;
            e_cfg[(s*NG+p)*CW +: CW]  = live[s] ? m_cfg[s][p] : 8'h00;
            e_tech[(s*NG+p)*TW +: TW] = live[s] ? m_tech[s]   : 16'h0000;
         end
      end
      check_val({tag, "_ie"},   pad_ie,       e_ie);
      check_val({tag, "_oen"},  pad_oen,      e_oen);
      check_val({tag, "_cfg"},  pad_cfg,      e_cfg);
      check_val({tag, "_tech"}, pad_tech_cfg, e_tech);
      check_val({tag, "_done"}, seq_done,     done);
   endtask

   task automatic bus_idle();
      reg_valid = 1'b0; reg_write = 1'b0; reg_addr = 8'h00; reg_wdata = 32'h0;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      reg_valid = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      reg_valid = 1'b1; reg_write = 1'b0; reg_addr = a; reg_wdata = 32'h0;
      @(negedge clk);
      bus_idle();
      check_val("rvalid", reg_rvalid, 1'b1);
   endtask

   // Drive start at c=0 (optionally one more CTRL write at inj_c) and check every cycle
   task automatic run_seq(input int ncyc, input int inj_c, input logic [31:0] inj_d);
      int       step;
      bit       forced;
      logic [3:0] live;
      step   = m_delay + 2;
      forced = 1'b0;
      for (int c = 0; c <= ncyc; c++) begin
         if (c == 0) begin
            reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 8'h00; reg_wdata = 32'h1;
         end else if (c == inj_c) begin
            reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 8'h00; reg_wdata = inj_d;
         end else begin
            bus_idle();
         end
         @(negedge clk);
         bus_idle();
         if (c == inj_c && inj_d[1]) forced = 1'b1;
         for (int s = 0; s < NS; s++) live[s] = !forced && (c >= step * (s + 1));
         check_pads($sformatf("seq_c%0d", c), live, !forced && (c >= step * NS));
      end
   endtask

   // Read scoreboard: every rvalid must match the oldest outstanding read
   always @(negedge clk) begin
      if (nreset === 1'b1 && reg_rvalid === 1'b1) begin
         check_val("rd_pending", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check_val("rdata", reg_rdata, exp_q.pop_front());
      end
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  base;
      bus_idle();
      model_reset();
      nreset = 1'b0;
      repeat (3) @(negedge clk);
      nreset = 1'b1;

      check_pads("reset", 4'b0000, 1'b0);
      check_val("rvalid_rst", reg_rvalid, 1'b0);
      check_val("rdata_rst", reg_rdata, 32'h0);
      check_val("ready", reg_ready, 1'b1);
      bus_rd(8'h01, 32'h0);
      bus_rd(8'h02, 32'h10);

      bus_wr(8'h20, 32'h1A5);
      m_ie[1] = 9'h1A5;
      bus_rd(8'h20, 32'h1A5);
      bus_rd(8'hFF, 32'h0);

      for (int s = 0; s < NS; s++) begin
         base = 8'h10 * 8'(s + 1);
         d = $urandom; bus_wr(base + 8'h0, d); m_ie[s]   = d[8:0];
         d = $urandom; bus_wr(base + 8'h1, d); m_oen[s]  = d[8:0];
         d = $urandom; bus_wr(base + 8'h2, d); m_tech[s] = d[15:0];
         for (int p = 0; p < NG; p++) begin
            d = $urandom; bus_wr(base + 8'(4 + p), d); m_cfg[s][p] = d[7:0];
         end
         bus_rd(base + 8'h1, {23'h0, m_oen[s]});
         bus_rd(base + 8'h2, {16'h0, m_tech[s]});
         bus_rd(base + 8'h4, {24'h0, m_cfg[s][0]});
         bus_rd(base + 8'hC, {24'h0, m_cfg[s][8]});
         bus_rd(base + 8'h3, 32'h0);
         bus_rd(base + 8'hD, 32'h0);
      end
      check_pads("programmed_safe", 4'b0000, 1'b0);

      bus_wr(8'h02, 32'h3);
      m_delay = 3;
      bus_rd(8'h02, 32'h3);
      run_seq(22, 3, 32'h1);
      bus_rd(8'h01, 32'h0303);

      bus_wr(8'h12, 32'h0000BEEF);
      check_pads("live_wr_old", 4'b1111, 1'b1);
      m_tech[0] = 16'hBEEF;
      @(negedge clk);
      check_pads("live_wr_new", 4'b1111, 1'b1);

      bus_wr(8'h00, 32'h2);
      check_pads("force_run", 4'b0000, 1'b0);
      bus_rd(8'h01, 32'h0);

      run_seq(16, 12, 32'h2);
      bus_rd(8'h01, 32'h0);
      run_seq(22, -1, 32'h0);

      bus_wr(8'h00, 32'h2);
      bus_wr(8'h00, 32'h3);
      repeat (8) @(negedge clk);
      check_pads("start_and_force", 4'b0000, 1'b0);
      bus_rd(8'h01, 32'h0);

      run_seq(12, -1, 32'h0);
      #2 nreset = 1'b0;
      #1;
      check_pads("async_rst", 4'b0000, 1'b0);
      check_val("async_rvalid", reg_rvalid, 1'b0);
      model_reset();
      @(negedge clk);
      nreset = 1'b1;
      bus_rd(8'h02, 32'h10);
      bus_rd(8'h01, 32'h0);
      bus_rd(8'h20, 32'h0);
      bus_rd(8'h21, 32'h1FF);
      check_pads("after_rst", 4'b0000, 1'b0);

      @(negedge clk);
      check_val("rd_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
